branch_resolve_unit: RTL and testbench

- Execute-stage partner of the 2-bit saturating-counter predictor.
- Buffers the fetch-stage prediction for each in-flight branch in a small FIFO.
- Resolves each branch from its operands and produces the actual outcome as a one-cycle update pulse for the predictor.
- On a misprediction, raises a registered redirect to fetch, flushes the prediction buffer and masks wrong-path execute slots for a fixed number of cycles.

---
 rtl/branch_resolve_unit_pkg.sv | 43 ++++
 rtl/branch_resolve_unit_pred_fifo.sv | 69 ++++++
 rtl/branch_resolve_unit.sv | 147 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: opcode, funct3 codes, FSM
// states and the direction/immediate helpers used by the execute-stage logic.
package branch_resolve_unit_pkg;

    localparam logic [6:0] OPCODE_BRANCH_SBTYPE = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Reserved funct3 codes (010/011) resolve as not-taken.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (funct3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return sa < sb;
            F3_BGE:  return sa >= sb;
            F3_BLTU: return a < b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // hi = inst[31:25], lo = inst[11:7]
    function automatic logic [31:0] b_imm(input logic [6:0] hi, input logic [4:0] lo);
        return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// Prediction buffer: DEPTH-entry synchronous FIFO with a clear that wins over
// push/pop; pops on an empty buffer and pushes into a full one are ignored.
module pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !clear && (!full || pop);
    assign do_pop  = pop && !clear && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: compares the buffered fetch prediction with
// the real outcome, trains the predictor and redirects fetch on a mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_push,
    input  logic             pred_taken_in,
    input  logic [31:0]      pred_target_in,
    output logic             pred_full,
    input  logic             ex_valid,
    input  logic [31:0]      ex_instruction,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             err_overflow,
    output logic             err_underflow
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_e           state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic             upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, misp_cnt_q, misp_cnt_d;
    logic             err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;

    logic        fifo_full, fifo_empty, fifo_push;
    logic [32:0] fifo_head;
    logic        resolve, actual, mispredict, pred_taken_h;
    logic [31:0] target, fallthrough;
    logic        unused_bits;

    assign unused_bits  = ^ex_instruction[24:15];
    assign resolve      = ex_valid && (ex_instruction[6:0] == OPCODE_BRANCH_SBTYPE) && (state_q == RUN);
    assign actual       = branch_taken(ex_instruction[14:12], rs1_val, rs2_val);
    assign target       = ex_pc + b_imm(ex_instruction[31:25], ex_instruction[11:7]);
    assign fallthrough  = ex_pc + 32'd4;
    // An empty buffer reads as a not-taken prediction.
    assign pred_taken_h = !fifo_empty && fifo_head[32];
    assign mispredict   = resolve && ((pred_taken_h != actual) ||
                                      (pred_taken_h && actual && (fifo_head[31:0] != target)));
    // Pushes during FLUSH or alongside a mispredict are wrong-path.
    assign fifo_push    = pred_push && (state_q == RUN) && !mispredict;

    pred_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_pred_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (resolve),
        .clear (mispredict),
        .din   ({pred_taken_in, pred_target_in}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) state_d = RUN;
                else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
        endcase
    end

    always_comb begin
        upd_valid_d      = resolve;
        upd_taken_d      = resolve && actual;
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        branch_cnt_d     = branch_cnt_q;
        misp_cnt_d       = misp_cnt_q;
        err_ovf_d        = err_ovf_q;
        err_unf_d        = err_unf_q;
        if (mispredict) begin
            redirect_pc_d = actual ? target : fallthrough;
            misp_cnt_d    = sat_inc(misp_cnt_q);
        end
        if (resolve) branch_cnt_d = sat_inc(branch_cnt_q);
        if (fifo_push && fifo_full && !resolve) err_ovf_d = 1'b1;
        if (resolve && fifo_empty) err_unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= RUN;
            flush_cnt_q      <= '0;
            upd_valid_q      <= 1'b0;
            upd_taken_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            misp_cnt_q       <= '0;
            err_ovf_q        <= 1'b0;
            err_unf_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            upd_valid_q      <= upd_valid_d;
            upd_taken_q      <= upd_taken_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            misp_cnt_q       <= misp_cnt_d;
            err_ovf_q        <= err_ovf_d;
            err_unf_q        <= err_unf_d;
        end
    end

    assign pred_full        = fifo_full;
    assign upd_valid        = upd_valid_q;
    assign upd_taken        = upd_taken_q;
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = misp_cnt_q;
    assign err_overflow     = err_ovf_q;
    assign err_underflow    = err_unf_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches queue their
// expected update/redirect; a negedge monitor pops and compares each pulse.
module tb_branch_resolve_unit;

    localparam logic [31:0] I_BEQ  = 32'h0020_8863;
    localparam logic [31:0] I_BNE  = 32'h0020_9863;
    localparam logic [31:0] I_F010 = 32'h0020_A863;
    localparam logic [31:0] I_BLT  = 32'h0020_C863;
    localparam logic [31:0] I_BLTU = 32'h0020_E863;
    localparam logic [31:0] I_BGEU = 32'h0020_F863;

    logic        clk, reset;
    logic        pred_push, pred_taken_in, pred_full;
    logic [31:0] pred_target_in;
    logic        ex_valid;
    logic [31:0] ex_instruction, ex_pc, rs1_val, rs2_val;
    logic        upd_valid, upd_taken, redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;
    logic        err_overflow, err_underflow;

    typedef struct packed {
        logic        taken;
        logic        redir;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .pred_push        (pred_push),
        .pred_taken_in    (pred_taken_in),
        .pred_target_in   (pred_target_in),
        .pred_full        (pred_full),
        .ex_valid         (ex_valid),
        .ex_instruction   (ex_instruction),
        .ex_pc            (ex_pc),
        .rs1_val          (rs1_val),
        .rs2_val          (rs2_val),
        .upd_valid        (upd_valid),
        .upd_taken        (upd_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .err_overflow     (err_overflow),
        .err_underflow    (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Monitor: every update pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (upd_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_upd: got upd_taken=%0b redirect_valid=%0b, expected no update",
                             upd_taken, redirect_valid);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (upd_taken !== mon_e.taken || redirect_valid !== mon_e.redir ||
                        (mon_e.redir && redirect_pc !== mon_e.pc)) begin
                        fails++;
                        $display("FAIL resolve: got taken=%0b redir=%0b pc=0x%08h, expected taken=%0b redir=%0b pc=0x%08h",
                                 upd_taken, redirect_valid, redirect_pc, mon_e.taken, mon_e.redir, mon_e.pc);
                    end
                end
            end else if (redirect_valid) begin
                tests++;
                fails++;
                $display("FAIL stray_redirect: got redirect_valid=1 pc=0x%08h without upd_valid, expected 0", redirect_pc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_upd_valid"}, {31'd0, upd_valid}, 0);
        chk({tag, "_upd_taken"}, {31'd0, upd_taken}, 0);
        chk({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 0);
        chk({tag, "_redirect_pc"}, redirect_pc, 0);
        chk({tag, "_branch_count"}, {16'd0, branch_count}, 0);
        chk({tag, "_mispredict_count"}, {16'd0, mispredict_count}, 0);
        chk({tag, "_err_overflow"}, {31'd0, err_overflow}, 0);
        chk({tag, "_err_underflow"}, {31'd0, err_underflow}, 0);
        chk({tag, "_pred_full"}, {31'd0, pred_full}, 0);
    endtask

    task automatic set_inputs(input logic push, input logic ptk, input logic [31:0] ptgt,
                              input logic exv, input logic [31:0] inst,
                              input logic [31:0] a, input logic [31:0] b);
        pred_push      = push;
        pred_taken_in  = ptk;
        pred_target_in = ptgt;
        ex_valid       = exv;
        ex_instruction = inst;
        ex_pc          = 32'h0000_0100;
        rs1_val        = a;
        rs2_val        = b;
    endtask

    // One cycle of stimulus; er=1 queues the expected resolution.
    task automatic slot(input logic push, input logic ptk, input logic [31:0] ptgt,
                        input logic exv, input logic [31:0] inst,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic er, input logic et, input logic ed, input logic [31:0] epc);
        @(posedge clk);
        #1;
        set_inputs(push, ptk, ptgt, exv, inst, a, b);
        if (er) exp_q.push_back('{taken: et, redir: ed, pc: epc});
    endtask

    task automatic idle();
        slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Correctly predicted BEQ
        slot(1, 1, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0);
        slot(0, 0, 0, 1, I_BEQ, 5, 5, 1, 1, 0, 0);
        idle();
        @(negedge clk);
        chk("beq_branch_count", {16'd0, branch_count}, 1);
        chk("beq_mispredict_count", {16'd0, mispredict_count}, 0);

        // Signed BLT mispredict; wrong-path and FLUSH-window pushes must be discarded
        slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        slot(1, 1, 32'h200, 1, I_BLT, 32'hFFFF_FFFF, 1, 1, 1, 1, 32'h110);
        slot(1, 1, 32'h110, 1, I_BEQ, 5, 5, 0, 0, 0, 0);
        slot(1, 1, 32'h110, 1, I_BEQ, 5, 5, 0, 0, 0, 0);
        slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        slot(0, 0, 0, 1, I_BNE, 7, 7, 1, 0, 0, 0);
        idle();
        @(negedge clk);
        chk("blt_branch_count", {16'd0, branch_count}, 3);
        chk("blt_mispredict_count", {16'd0, mispredict_count}, 1);
        chk("blt_redirect_pc_hold", redirect_pc, 32'h110);
        chk("blt_err_underflow", {31'd0, err_underflow}, 0);

        // Unsigned BLTU not taken against a taken prediction, then a correct BGEU
        slot(1, 1, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0);
        slot(0, 0, 0, 1, I_BLTU, 32'hFFFF_FFFF, 1, 1, 0, 1, 32'h104);
        idle();
        idle();
        slot(1, 1, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0);
        slot(0, 0, 0, 1, I_BGEU, 32'hFFFF_FFFF, 1, 1, 1, 0, 0);
        idle();
        @(negedge clk);
        chk("bltu_redirect_pc_hold", redirect_pc, 32'h104);
        chk("bltu_branch_count", {16'd0, branch_count}, 5);
        chk("bltu_mispredict_count", {16'd0, mispredict_count}, 2);

        // Direction right, target wrong
        slot(1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
        slot(0, 0, 0, 1, I_BEQ, 9, 9, 1, 1, 1, 32'h110);
        idle();
        idle();
        // Reserved funct3 resolves not-taken
        slot(1, 1, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0);
        slot(0, 0, 0, 1, I_F010, 3, 3, 1, 0, 1, 32'h104);
        idle();
        idle();
        @(negedge clk);
        chk("f010_branch_count", {16'd0, branch_count}, 7);
        chk("f010_mispredict_count", {16'd0, mispredict_count}, 4);

        // FIFO overflow then underflow
        for (int i = 0; i < 4; i++) slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("fifo_full_after_4", {31'd0, pred_full}, 1);
        chk("fifo_no_overflow_yet", {31'd0, err_overflow}, 0);
        idle();
        @(negedge clk);
        chk("fifo_overflow", {31'd0, err_overflow}, 1);
        for (int i = 0; i < 4; i++) slot(0, 0, 0, 1, I_BNE, 7, 7, 1, 0, 0, 0);
        slot(0, 0, 0, 1, I_BNE, 7, 7, 1, 0, 0, 0);
        @(negedge clk);
        chk("fifo_not_full", {31'd0, pred_full}, 0);
        chk("fifo_no_underflow_yet", {31'd0, err_underflow}, 0);
        idle();
        @(negedge clk);
        chk("fifo_underflow", {31'd0, err_underflow}, 1);
        chk("fifo_branch_count", {16'd0, branch_count}, 12);
        chk("fifo_mispredict_count", {16'd0, mispredict_count}, 4);

        // Asynchronous reset while the redirect pulse is up and FSM is in FLUSH
        slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        slot(0, 0, 0, 1, I_BLT, 32'hFFFF_FFFF, 1, 1, 1, 1, 32'h110);
        idle();
        #1;
        chk("redirect_before_reset", {31'd0, redirect_valid}, 1);
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        @(negedge clk);
        set_inputs(0, 0, 0, 1, I_BNE, 7, 7);
        exp_q.push_back('{taken: 1'b0, redir: 1'b0, pc: 32'h0});
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("post_reset_branch_count", {16'd0, branch_count}, 1);
        chk("post_reset_err_underflow", {31'd0, err_underflow}, 1);
        chk("post_reset_err_overflow", {31'd0, err_overflow}, 0);

        idle();
        idle();
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
